// File: rtl/vme_mem_master.sv
// vme_mem_master: single-outstanding command/response bridge to a VME-style strobe/done memory bus
// with a per-access wait timeout and a saturating timeout counter.
module vme_mem_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic                  CmdWrite,
  input  logic [ADDR_WIDTH-1:0] CmdAddr,
  input  logic [31:0]           CmdWrData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [31:0]           RspRdData,
  output logic                  RspError,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic [31:0]           VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [31:0]           VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  output logic [7:0]            TimeoutCnt
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic          r_write;
  logic [CW-1:0] r_cnt;
  logic          w_done;
  logic          w_tmo;
  assign w_done = r_write ? VMEWrDone : VMERdDone;
  // r_cnt is 0 during the first WAIT cycle, so TIMEOUT-1 marks the last allowed one
  assign w_tmo  = r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      CmdReady   <= 1'b0;
      RspValid   <= 1'b0;
      RspRdData  <= '0;
      RspError   <= 1'b0;
      VMEAddr    <= '0;
      VMEWrData  <= '0;
      VMERdMem   <= 1'b0;
      VMEWrMem   <= 1'b0;
      TimeoutCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (CmdValid && CmdReady) begin
            r_state   <= WAIT;
            CmdReady  <= 1'b0;
            r_write   <= CmdWrite;
            r_cnt     <= '0;
            VMEAddr   <= CmdAddr;
            VMEWrData <= CmdWrData;
            VMEWrMem  <= CmdWrite;
            VMERdMem  <= !CmdWrite;
          end else begin
            CmdReady  <= 1'b1;
          end
        end
        WAIT: begin
          VMEWrMem <= 1'b0;
          VMERdMem <= 1'b0;
          r_cnt    <= r_cnt + 1'b1;
          // a matching Done beats a coincident timeout
          if (w_done) begin
            r_state   <= RESP;
            RspValid  <= 1'b1;
            RspError  <= 1'b0;
            RspRdData <= r_write ? 32'h0 : VMERdData;
          end else if (w_tmo) begin
            r_state    <= RESP;
            RspValid   <= 1'b1;
            RspError   <= 1'b1;
            RspRdData  <= 32'h0;
            TimeoutCnt <= (TimeoutCnt == 8'hFF) ? TimeoutCnt : TimeoutCnt + 1'b1;
          end
        end
        RESP: begin
          if (RspReady) begin
            r_state  <= IDLE;
            RspValid <= 1'b0;
            CmdReady <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vme_mem_master.sv
// tb_vme_mem_master: table-driven, randomized and hand-sequenced checks of vme_mem_master
// against a transaction-level expectation model (TIMEOUT=4).
module tb_vme_mem_master;
  localparam int TO = 4;
  logic        Clk = 0, Rst_n = 0;
  logic        CmdValid = 0, CmdWrite = 0, RspReady = 0;
  logic [7:0]  CmdAddr = 0;
  logic [31:0] CmdWrData = 0, VMERdData = 0;
  logic        VMERdDone = 0, VMEWrDone = 0;
  logic        CmdReady, RspValid, RspError, VMERdMem, VMEWrMem;
  logic [31:0] RspRdData, VMEWrData;
  logic [7:0]  VMEAddr, TimeoutCnt;

  vme_mem_master #(.ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
    .CmdAddr(CmdAddr), .CmdWrData(CmdWrData), .RspValid(RspValid), .RspReady(RspReady),
    .RspRdData(RspRdData), .RspError(RspError), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData), .VMERdDone(VMERdDone),
    .VMEWrDone(VMEWrDone), .TimeoutCnt(TimeoutCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          done_at;
    bit          wrong;
    logic [31:0] rdata;
    int          hold;
    bit          late;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  int checks = 0, errors = 0;
  int tcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err  = v.wrong || v.done_at == 0 || v.done_at > TO;
    r.exp_data = (r.exp_err || v.wr) ? 32'h0 : v.rdata;
    return r;
  endfunction

  task automatic run_access(input vec_t v);
    int  c;
    bit  got;
    bit  pulse_wr;
    int  exp_cyc;
    logic [7:0]  a;
    logic [31:0] d;
    exp_cyc  = v.exp_err ? TO : v.done_at;
    pulse_wr = v.wr ^ v.wrong;
    @(negedge Clk);
    CmdValid = 1; CmdWrite = v.wr; CmdAddr = v.addr; CmdWrData = v.wdata;
    c = 0;
    while (!CmdReady && c < 10) begin @(negedge Clk); c++; end
    chk("cmd_ready_idle", CmdReady, 1);
    @(negedge Clk);
    CmdValid = 0;
    a = 8'($urandom); d = $urandom;
    CmdAddr = a; CmdWrData = d;
    chk("wr_strobe", VMEWrMem, v.wr);
    chk("rd_strobe", VMERdMem, !v.wr);
    chk("vme_addr", VMEAddr, v.addr);
    chk("vme_wdata", VMEWrData, v.wdata);
    chk("cmd_ready_busy", CmdReady, 0);
    c = 1; got = 0;
    while (!got && c <= TO + 2) begin
      VMERdData = (c == v.done_at) ? v.rdata : $urandom;
      VMEWrDone = (c == v.done_at) && pulse_wr;
      VMERdDone = (c == v.done_at) && !pulse_wr;
      @(negedge Clk);
      chk("strobe_once", {VMEWrMem, VMERdMem}, 0);
      got = RspValid;
      c++;
    end
    VMEWrDone = 0; VMERdDone = 0; VMERdData = $urandom;
    chk("rsp_valid", got, 1);
    chk("wait_cycles", c - 1, exp_cyc);
    if (v.exp_err && tcnt < 255) tcnt++;
    chk("rsp_data", RspRdData, v.exp_data);
    chk("rsp_err", RspError, v.exp_err);
    chk("timeout_cnt", TimeoutCnt, tcnt);
    chk("addr_hold", VMEAddr, v.addr);
    for (int h = 0; h < v.hold; h++) begin
      VMEWrDone = v.late && h == 1 && v.wr;
      VMERdDone = v.late && h == 1 && !v.wr;
      @(negedge Clk);
      chk("hold_valid", RspValid, 1);
      chk("hold_data", RspRdData, v.exp_data);
      chk("hold_err", RspError, v.exp_err);
      chk("hold_cmd_ready", CmdReady, 0);
      chk("hold_tcnt", TimeoutCnt, tcnt);
    end
    VMEWrDone = 0; VMERdDone = 0;
    RspReady = 1;
    @(negedge Clk);
    RspReady = 0;
    chk("rsp_done", RspValid, 0);
    chk("ready_after_rsp", CmdReady, 1);
  endtask

  vec_t tab[7];
  vec_t rv;
  int acc, strobes, rsps, viol;

  initial begin
    tab[0] = '{1, 8'h00, 32'h00003FFF, 3, 0, 32'h0,        0, 0, 32'h0,        0};
    tab[1] = '{0, 8'h00, 32'h0,        2, 0, 32'h00002ABC, 5, 0, 32'h00002ABC, 0};
    tab[2] = '{0, 8'h5A, 32'h0,        0, 0, 32'h11111111, 3, 1, 32'h0,        1};
    tab[3] = '{1, 8'h33, 32'hDEADBEEF, 4, 0, 32'h0,        0, 0, 32'h0,        0};
    tab[4] = '{1, 8'hC3, 32'hCAFEF00D, 2, 1, 32'h22222222, 1, 0, 32'h0,        1};
    tab[5] = '{0, 8'hFF, 32'h0,        1, 0, 32'h12345678, 2, 1, 32'h12345678, 0};
    tab[6] = '{0, 8'h81, 32'h0,        1, 1, 32'h33333333, 0, 0, 32'h0,        1};

    repeat (3) @(negedge Clk);
    chk("reset_outs", {CmdReady, RspValid, RspError, VMERdMem, VMEWrMem}, 0);
    chk("reset_data", RspRdData | VMEWrData, 0);
    chk("reset_addr", VMEAddr, 0);
    chk("reset_tcnt", TimeoutCnt, 0);
    Rst_n = 1;
    #1 chk("ready_before_clk", CmdReady, 0);
    @(negedge Clk);
    chk("ready_after_release", CmdReady, 1);

    for (int i = 0; i < 7; i++) run_access(tab[i]);

    // reset in the middle of a write, then a stray Done after release
    @(negedge Clk);
    CmdValid = 1; CmdWrite = 1; CmdAddr = 8'h77; CmdWrData = 32'hA5A5A5A5;
    @(negedge Clk);
    CmdValid = 0;
    chk("mid_strobe", VMEWrMem, 1);
    @(negedge Clk);
    Rst_n = 0;
    #1;
    chk("mid_rst_outs", {CmdReady, RspValid, RspError, VMERdMem, VMEWrMem}, 0);
    chk("mid_rst_data", RspRdData | VMEWrData, 0);
    chk("mid_rst_addr", VMEAddr, 0);
    chk("mid_rst_tcnt", TimeoutCnt, 0);
    tcnt = 0;
    @(negedge Clk);
    Rst_n = 1; VMEWrDone = 1;
    @(negedge Clk);
    VMEWrDone = 0;
    chk("late_done_ready", CmdReady, 1);
    chk("late_done_valid", RspValid, 0);
    repeat (2) begin
      @(negedge Clk);
      chk("late_done_idle", {RspValid, VMEWrMem, VMERdMem}, 0);
    end
    run_access(tab[0]);

    // back-to-back writes with RspReady tied high and done on the strobe cycle
    acc = 0; strobes = 0; rsps = 0; viol = 0;
    @(negedge Clk);
    CmdValid = 1; CmdWrite = 1; CmdAddr = 8'h10; CmdWrData = 32'h0BADF00D; RspReady = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (acc == 3) CmdValid = 0;
      VMEWrDone = VMEWrMem;
      if (CmdValid && CmdReady) acc++;
      if (VMEWrMem) strobes++;
      if (RspValid && RspReady) rsps++;
      if (CmdReady && (VMEWrMem || RspValid)) viol++;
      if (strobes > rsps + 1 || VMERdMem) viol++;
      @(negedge Clk);
    end
    CmdValid = 0; RspReady = 0; VMEWrDone = 0;
    chk("b2b_accepts", acc, 3);
    chk("b2b_strobes", strobes, 3);
    chk("b2b_rsps", rsps, 3);
    chk("b2b_overlap", viol, 0);

    for (int i = 0; i < 25; i++) begin
      rv.wr = 1'($urandom); rv.addr = 8'($urandom); rv.wdata = $urandom;
      rv.done_at = $urandom_range(0, 6); rv.wrong = ($urandom_range(0, 3) == 0);
      rv.rdata = $urandom; rv.hold = $urandom_range(0, 2); rv.late = 1'($urandom);
      run_access(model(rv));
    end

    // drive TimeoutCnt into saturation
    rv = '{0, 8'h42, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0};
    for (int i = 0; i < 256; i++) run_access(model(rv));
    chk("tcnt_saturated", TimeoutCnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
